secuenciador_carga: RTL and testbench
=====================================

Name: secuenciador_carga

Overview:
- Multi-cycle load sequencer beside the single-cycle control unit.
- Executes the memory-addressing instructions: immediate, direct, indirect, register-indirect and base-relative loads.
- Stalls the PC, drives a req/ack data-memory port, and writes the loaded byte into the register file.
- All other opcodes pass through untouched; the control unit keeps handling ALU and jump instructions.

Parameters:
- DATA_W, 8, register/memory data width.
- ADDR_W, 16, data-memory address width; equals the instruction address/immediate field width.
- TIMEOUT, 16, maximum cycles req may stay high without ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  8  current instruction opcode.
- campo  in  ADDR_W  instruction immediate/address field.
- rd  in  4  destination register index.
- reg_a  in  DATA_W  register-file read data for the instruction's source register.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  memory read address.
- mem_ack  in  1  read complete; mem_rdata valid this cycle.
- mem_rdata  in  DATA_W  memory read data.
- stall  out  1  hold PC, and suppress control-unit we3/wez.
- rf_we  out  1  register-file write enable for the loaded value.
- rf_wa  out  4  register-file write address.
- rf_wd  out  DATA_W  register-file write data.
- busy  out  1  FSM not in IDLE.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: state=IDLE, timeout counter=0.
- Reset outputs: mem_req=0, mem_addr=0, rf_we=0, rf_wa=0, rf_wd=0, err=0, busy=0, stall=0.
- Opcodes handled:
  - 0x10 LDI: rd=campo[DATA_W-1:0].
  - 0x11 LDD: rd=M[campo].
  - 0x12 LDN: ptr={M[campo+1],M[campo]} (little-endian), then rd=M[ptr].
  - 0x13 LDR: rd=M[zext(reg_a)].
  - 0x14 LDX: rd=M[campo+zext(reg_a)]; sum taken mod 2^ADDR_W.
  - campo+1 wraps 0xFFFF -> 0x0000.
- IDLE:
  - stall is asserted combinationally when opcode is 0x10-0x14; otherwise stall=0.
  - Latch rd, opcode and the computed first address.
  - LDI -> WB with rf_wd preloaded.
  - LDD/LDR/LDX -> RD_DATA.
  - LDN -> RD_PLO.
- Read states (RD_PLO, RD_PHI, RD_DATA):
  - mem_req=1 and mem_addr stable for the whole state, until the cycle mem_ack=1.
  - mem_rdata is sampled on the ack cycle and mem_req drops the next cycle.
  - RD_PLO: capture ptr low byte -> RD_PHI at campo+1.
  - RD_PHI: capture high byte -> RD_DATA at ptr.
  - RD_DATA: capture into rf_wd -> WB.
- WB:
  - One cycle with rf_we=1, rf_wa=latched rd, stall=0, so the PC advances at the end of WB.
  - Then IDLE.
  - The opcode presented during WB is still the load; the FSM ignores it (no re-trigger), and IDLE evaluates the next opcode.
- stall=1 in every state except WB and ABORT; busy=1 outside IDLE.
- Latency with zero-wait memory (ack in first req cycle):
  - LDI 2 cycles.
  - LDD/LDR/LDX 3 cycles.
  - LDN 5 cycles.
  - Each wait cycle adds 1.
- Timeout:
  - The counter increments each cycle req=1 and ack=0, and clears on ack or state exit.
  - When the count reaches TIMEOUT without ack -> ABORT.
- ABORT:
  - One cycle with err=1, rf_we=0, mem_req=0, stall=0 (PC skips the instruction), then IDLE.
  - mem_ack arriving in the same cycle as the timeout hit wins: the data is accepted and there is no abort.
- Spurious mem_ack while mem_req=0: ignored.
- Reset mid-operation: immediate return to IDLE, no register write, mem_req=0 the following cycle.
- rd=0 is written like any other register; the register file decides any r0 semantics.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants OP_LDI..OP_LDX.
  - State enum {IDLE, RD_PLO, RD_PHI, RD_DATA, WB, ABORT}.
  - DATA_W/ADDR_W defaults.
- Natural sub-module: temporizador_ack, the timeout counter with clear/enable/expired; everything else is a single FSM.

Test Plan:
- LDI: opcode=0x10, campo=0x00A5, rd=3 -> stall 1 cycle, then rf_we=1 with rf_wa=3, rf_wd=0xA5; mem_req never high.
- LDD with 2 wait states: campo=0x0040, M[0x40]=0x5C -> mem_addr=0x0040 held 3 cycles, write r=rd with 0x5C, total 5 cycles.
- LDN: campo=0xFFFF, M[0xFFFF]=0x34, M[0x0000]=0x12, M[0x1234]=0x77 -> addresses 0xFFFF, 0x0000, 0x1234 in order, rf_wd=0x77, 5 cycles with zero-wait memory.
- LDX: campo=0xFFF0, reg_a=0x20 -> mem_addr=0x0010 (wrap).
- LDR: reg_a=0x80 -> mem_addr=0x0080.
- Timeout: TIMEOUT=4, ack never asserted -> req high 4 cycles, ABORT with err=1 for 1 cycle, rf_we stays 0, stall=0.
- Ack on the 4th cycle -> normal writeback, err=0.
- Reset asserted in RD_PHI -> next cycle IDLE, mem_req=0, busy=0, no rf_we.
- ALU opcode 0xA0 -> stall=0, busy=0, no memory activity.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state and width definitions for the load sequencer
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 16;

  localparam logic [7:0] OP_LDI = 8'h10;
  localparam logic [7:0] OP_LDD = 8'h11;
  localparam logic [7:0] OP_LDN = 8'h12;
  localparam logic [7:0] OP_LDR = 8'h13;
  localparam logic [7:0] OP_LDX = 8'h14;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_PLO  = 3'd1;
  localparam logic [2:0] ST_RD_PHI  = 3'd2;
  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_ABORT   = 3'd5;

  function automatic logic es_carga(input logic [7:0] op);
    return (op >= OP_LDI) && (op <= OP_LDX);
  endfunction

endpackage

// File: rtl/temporizador_ack.sv
// rtl/temporizador_ack.sv - counts unacknowledged request cycles and flags the timeout
module temporizador_ack #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (TIMEOUT != 0)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires during the TIMEOUT-th waiting cycle; it must not depend on clear_i,
  // which is itself derived from the FSM's next state.
  assign expired_o = (TIMEOUT != 0) && enable_i && (count_q == LIMIT);

endmodule

// File: rtl/secuenciador_carga.sv
// rtl/secuenciador_carga.sv - multi-cycle load sequencer driving the data-memory port and register write
module secuenciador_carga
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        opcode,
  input  logic [ADDR_W-1:0] campo,
  input  logic [3:0]        rd,
  input  logic [DATA_W-1:0] reg_a,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              rf_we,
  output logic [3:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              busy,
  output logic              err
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] ptr_lo_q, ptr_lo_d;
  logic              expirado;
  logic              en_lectura;

  assign en_lectura = (state_q == ST_RD_PLO) || (state_q == ST_RD_PHI) ||
                      (state_q == ST_RD_DATA);

  temporizador_ack #(
    .TIMEOUT(TIMEOUT)
  ) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (mem_ack || (state_d != state_q)),
    .enable_i (en_lectura && !mem_ack),
    .expired_o(expirado)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    data_d   = data_q;
    ptr_lo_d = ptr_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (es_carga(opcode)) begin
          rd_d = rd;
          case (opcode)
            OP_LDI: begin
              data_d  = campo[DATA_W-1:0];
              state_d = ST_WB;
            end
            OP_LDD: begin
              addr_d  = campo;
              state_d = ST_RD_DATA;
            end
            OP_LDN: begin
              addr_d  = campo;
              state_d = ST_RD_PLO;
            end
            OP_LDR: begin
              addr_d  = ADDR_W'(reg_a);
              state_d = ST_RD_DATA;
            end
            OP_LDX: begin
              addr_d  = campo + ADDR_W'(reg_a);
              state_d = ST_RD_DATA;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      // An ack in the same cycle as the timeout takes precedence.
      ST_RD_PLO: begin
        if (mem_ack) begin
          ptr_lo_d = mem_rdata;
          addr_d   = addr_q + 1'b1;
          state_d  = ST_RD_PHI;
        end else if (expirado) begin
          state_d = ST_ABORT;
        end
      end
      ST_RD_PHI: begin
        if (mem_ack) begin
          addr_d  = ADDR_W'({mem_rdata, ptr_lo_q});
          state_d = ST_RD_DATA;
        end else if (expirado) begin
          state_d = ST_ABORT;
        end
      end
      ST_RD_DATA: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = ST_WB;
        end else if (expirado) begin
          state_d = ST_ABORT;
        end
      end
      ST_WB:    state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      ptr_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      ptr_lo_q <= ptr_lo_d;
    end
  end

  assign mem_req  = en_lectura;
  assign mem_addr = addr_q;
  assign rf_we    = (state_q == ST_WB);
  assign rf_wa    = rd_q;
  assign rf_wd    = data_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = (state_q == ST_ABORT);
  // WB and ABORT release the PC so it advances past the instruction.
  assign stall    = (state_q == ST_IDLE) ? es_carga(opcode) :
                    !((state_q == ST_WB) || (state_q == ST_ABORT));

endmodule

// File: tb/tb_secuenciador_carga.sv
// tb/tb_secuenciador_carga.sv - directed self-checking bench for the load sequencer
module tb_secuenciador_carga;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  opcode;
  logic [15:0] campo;
  logic [3:0]  rd;
  logic [7:0]  reg_a;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        stall;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [7:0]  rf_wd;
  logic        busy;
  logic        err;
  logic [4:0]  flags;

  int passed = 0;
  int total  = 0;

  // Per-cycle vector: inputs, expected {stall,busy,mem_req,rf_we,err}, address and writeback.
  typedef struct {
    logic [7:0]  op;
    logic        ack;
    logic [7:0]  rdat;
    logic        rst;
    logic [4:0]  fl;
    logic [15:0] addr;
    logic [3:0]  wa;
    logic [7:0]  wd;
  } vec_t;

  vec_t v[$];

  always #5 clk = ~clk;

  assign flags = {stall, busy, mem_req, rf_we, err};

  secuenciador_carga #(
    .DATA_W (8),
    .ADDR_W (16),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .campo    (campo),
    .rd       (rd),
    .reg_a    (reg_a),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .stall    (stall),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .busy     (busy),
    .err      (err)
  );

  function automatic vec_t mk(input logic [7:0] op, input logic ack, input logic [7:0] rdat,
                              input logic rst, input logic [4:0] fl, input logic [15:0] addr,
                              input logic [3:0] wa, input logic [7:0] wd);
    vec_t x;
    x.op = op; x.ack = ack; x.rdat = rdat; x.rst = rst;
    x.fl = fl; x.addr = addr; x.wa = wa; x.wd = wd;
    return x;
  endfunction

  task automatic apply(input vec_t x);
    opcode    = x.op;
    mem_ack   = x.ack;
    mem_rdata = x.rdat;
    reset     = x.rst;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 8'h00; campo = 16'h0000; rd = 4'd0; reg_a = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (flags !== 5'b00000) $display("FAIL reset_flags got %b exp %b", flags, 5'b00000);
    else passed++;
    total++;
    if (mem_addr !== 16'h0000) $display("FAIL reset_addr got %h exp 0000", mem_addr);
    else passed++;
    total++;
    if (rf_wa !== 4'd0) $display("FAIL reset_wa got %0d exp 0", rf_wa);
    else passed++;
    total++;
    if (rf_wd !== 8'h00) $display("FAIL reset_wd got %h exp 00", rf_wd);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ldi();
    campo = 16'h00A5; rd = 4'd3; reg_a = 8'h00;
    v = {};
    v.push_back(mk(8'h10, 1'b0, 8'h00, 1'b0, 5'b10000, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'h10, 1'b0, 8'h00, 1'b0, 5'b01010, 16'h0000, 4'd3, 8'hA5));
    v.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
    foreach (v[c]) begin
      apply(v[c]); #1;
      total++;
      if (flags !== v[c].fl) $display("FAIL ldi_flags c%0d got %b exp %b", c, flags, v[c].fl);
      else passed++;
      if (v[c].fl[1]) begin
        total++;
        if ({rf_wa, rf_wd} !== {v[c].wa, v[c].wd})
          $display("FAIL ldi_wb c%0d got %0d/%h exp %0d/%h", c, rf_wa, rf_wd, v[c].wa, v[c].wd);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ldd_wait();
    campo = 16'h0040; rd = 4'd5; reg_a = 8'h00;
    v = {};
    v.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 5'b10000, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 5'b11100, 16'h0040, 4'd0, 8'h00));
    v.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 5'b11100, 16'h0040, 4'd0, 8'h00));
    v.push_back(mk(8'h11, 1'b1, 8'h5C, 1'b0, 5'b11100, 16'h0040, 4'd0, 8'h00));
    v.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 5'b01010, 16'h0000, 4'd5, 8'h5C));
    v.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
    foreach (v[c]) begin
      apply(v[c]); #1;
      total++;
      if (flags !== v[c].fl) $display("FAIL ldd_flags c%0d got %b exp %b", c, flags, v[c].fl);
      else passed++;
      if (v[c].fl[2]) begin
        total++;
        if (mem_addr !== v[c].addr) $display("FAIL ldd_addr c%0d got %h exp %h", c, mem_addr, v[c].addr);
        else passed++;
      end
      if (v[c].fl[1]) begin
        total++;
        if ({rf_wa, rf_wd} !== {v[c].wa, v[c].wd})
          $display("FAIL ldd_wb c%0d got %0d/%h exp %0d/%h", c, rf_wa, rf_wd, v[c].wa, v[c].wd);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ldn_wrap();
    campo = 16'hFFFF; rd = 4'd7; reg_a = 8'h00;
    v = {};
    // Acks in IDLE and WB are spurious and must be ignored.
    v.push_back(mk(8'h12, 1'b1, 8'hEE, 1'b0, 5'b10000, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'h12, 1'b1, 8'h34, 1'b0, 5'b11100, 16'hFFFF, 4'd0, 8'h00));
    v.push_back(mk(8'h12, 1'b1, 8'h12, 1'b0, 5'b11100, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'h12, 1'b1, 8'h77, 1'b0, 5'b11100, 16'h1234, 4'd0, 8'h00));
    v.push_back(mk(8'h12, 1'b1, 8'hEE, 1'b0, 5'b01010, 16'h0000, 4'd7, 8'h77));
    v.push_back(mk(8'h00, 1'b1, 8'hEE, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
    foreach (v[c]) begin
      apply(v[c]); #1;
      total++;
      if (flags !== v[c].fl) $display("FAIL ldn_flags c%0d got %b exp %b", c, flags, v[c].fl);
      else passed++;
      if (v[c].fl[2]) begin
        total++;
        if (mem_addr !== v[c].addr) $display("FAIL ldn_addr c%0d got %h exp %h", c, mem_addr, v[c].addr);
        else passed++;
      end
      if (v[c].fl[1]) begin
        total++;
        if ({rf_wa, rf_wd} !== {v[c].wa, v[c].wd})
          $display("FAIL ldn_wb c%0d got %0d/%h exp %0d/%h", c, rf_wa, rf_wd, v[c].wa, v[c].wd);
        else passed++;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_ldx_ldr();
    logic [7:0]  ops   [2];
    logic [15:0] camps [2];
    logic [7:0]  regs  [2];
    logic [3:0]  rds   [2];
    logic [15:0] addrs [2];
    logic [7:0]  datos [2];
    ops   = '{8'h14, 8'h13};
    camps = '{16'hFFF0, 16'h1234};
    regs  = '{8'h20, 8'h80};
    rds   = '{4'd2, 4'd0};
    addrs = '{16'h0010, 16'h0080};
    datos = '{8'h9A, 8'h3C};
    for (int k = 0; k < 2; k++) begin
      campo = camps[k]; reg_a = regs[k]; rd = rds[k];
      v = {};
      v.push_back(mk(ops[k], 1'b0, 8'h00, 1'b0, 5'b10000, 16'h0000, 4'd0, 8'h00));
      v.push_back(mk(ops[k], 1'b1, datos[k], 1'b0, 5'b11100, addrs[k], 4'd0, 8'h00));
      v.push_back(mk(ops[k], 1'b0, 8'h00, 1'b0, 5'b01010, 16'h0000, rds[k], datos[k]));
      v.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
      foreach (v[c]) begin
        apply(v[c]); #1;
        total++;
        if (flags !== v[c].fl) $display("FAIL ldxr%0d_flags c%0d got %b exp %b", k, c, flags, v[c].fl);
        else passed++;
        if (v[c].fl[2]) begin
          total++;
          if (mem_addr !== v[c].addr) $display("FAIL ldxr%0d_addr c%0d got %h exp %h", k, c, mem_addr, v[c].addr);
          else passed++;
        end
        if (v[c].fl[1]) begin
          total++;
          if ({rf_wa, rf_wd} !== {v[c].wa, v[c].wd})
            $display("FAIL ldxr%0d_wb c%0d got %0d/%h exp %0d/%h", k, c, rf_wa, rf_wd, v[c].wa, v[c].wd);
          else passed++;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_timeout();
    logic       ack4;
    logic [4:0] fl5;
    campo = 16'h0200; rd = 4'd4; reg_a = 8'h00;
    // Pass 0: ack never comes -> ABORT. Pass 1: ack on the 4th request cycle wins.
    for (int k = 0; k < 2; k++) begin
      ack4 = (k == 1);
      fl5  = (k == 1) ? 5'b01010 : 5'b01001;
      v = {};
      v.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 5'b10000, 16'h0000, 4'd0, 8'h00));
      v.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 5'b11100, 16'h0200, 4'd0, 8'h00));
      v.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 5'b11100, 16'h0200, 4'd0, 8'h00));
      v.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 5'b11100, 16'h0200, 4'd0, 8'h00));
      v.push_back(mk(8'h11, ack4, 8'h66, 1'b0, 5'b11100, 16'h0200, 4'd0, 8'h00));
      v.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, fl5, 16'h0000, 4'd4, 8'h66));
      v.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
      foreach (v[c]) begin
        apply(v[c]); #1;
        total++;
        if (flags !== v[c].fl) $display("FAIL tmo%0d_flags c%0d got %b exp %b", k, c, flags, v[c].fl);
        else passed++;
        if (v[c].fl[2]) begin
          total++;
          if (mem_addr !== v[c].addr) $display("FAIL tmo%0d_addr c%0d got %h exp %h", k, c, mem_addr, v[c].addr);
          else passed++;
        end
        if (v[c].fl[1]) begin
          total++;
          if ({rf_wa, rf_wd} !== {v[c].wa, v[c].wd})
            $display("FAIL tmo%0d_wb c%0d got %0d/%h exp %0d/%h", k, c, rf_wa, rf_wd, v[c].wa, v[c].wd);
          else passed++;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    campo = 16'h0100; rd = 4'd6; reg_a = 8'h00;
    v = {};
    v.push_back(mk(8'h12, 1'b0, 8'h00, 1'b0, 5'b10000, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'h12, 1'b1, 8'h11, 1'b0, 5'b11100, 16'h0100, 4'd0, 8'h00));
    v.push_back(mk(8'h12, 1'b0, 8'h00, 1'b1, 5'b11100, 16'h0101, 4'd0, 8'h00));
    v.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
    foreach (v[c]) begin
      apply(v[c]); #1;
      total++;
      if (flags !== v[c].fl) $display("FAIL rstmid_flags c%0d got %b exp %b", c, flags, v[c].fl);
      else passed++;
      if (v[c].fl[2]) begin
        total++;
        if (mem_addr !== v[c].addr) $display("FAIL rstmid_addr c%0d got %h exp %h", c, mem_addr, v[c].addr);
        else passed++;
      end
      @(negedge clk);
    end
    #1;
    total++;
    if ({mem_addr, rf_wd} !== 24'h0) $display("FAIL rstmid_clear got %h/%h exp 0000/00", mem_addr, rf_wd);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_alu_pass();
    campo = 16'h0040; rd = 4'd1; reg_a = 8'h55;
    v = {};
    v.push_back(mk(8'hA0, 1'b0, 8'h00, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'hA0, 1'b1, 8'hFF, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'h15, 1'b0, 8'h00, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'h0F, 1'b0, 8'h00, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
    foreach (v[c]) begin
      apply(v[c]); #1;
      total++;
      if (flags !== v[c].fl) $display("FAIL alu_flags c%0d got %b exp %b", c, flags, v[c].fl);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    campo = 16'h0011; rd = 4'd1; reg_a = 8'h05;
    v = {};
    v.push_back(mk(8'h10, 1'b0, 8'h00, 1'b0, 5'b10000, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'h10, 1'b0, 8'h00, 1'b0, 5'b01010, 16'h0000, 4'd1, 8'h11));
    v.push_back(mk(8'h13, 1'b0, 8'h00, 1'b0, 5'b10000, 16'h0000, 4'd0, 8'h00));
    v.push_back(mk(8'h13, 1'b1, 8'h42, 1'b0, 5'b11100, 16'h0005, 4'd0, 8'h00));
    v.push_back(mk(8'h13, 1'b0, 8'h00, 1'b0, 5'b01010, 16'h0000, 4'd9, 8'h42));
    v.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 5'b00000, 16'h0000, 4'd0, 8'h00));
    foreach (v[c]) begin
      if (c == 2) rd = 4'd9;
      apply(v[c]); #1;
      total++;
      if (flags !== v[c].fl) $display("FAIL b2b_flags c%0d got %b exp %b", c, flags, v[c].fl);
      else passed++;
      if (v[c].fl[2]) begin
        total++;
        if (mem_addr !== v[c].addr) $display("FAIL b2b_addr c%0d got %h exp %h", c, mem_addr, v[c].addr);
        else passed++;
      end
      if (v[c].fl[1]) begin
        total++;
        if ({rf_wa, rf_wd} !== {v[c].wa, v[c].wd})
          $display("FAIL b2b_wb c%0d got %0d/%h exp %0d/%h", c, rf_wa, rf_wd, v[c].wa, v[c].wd);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_ldd_wait();
    test_ldn_wrap();
    test_ldx_ldr();
    test_timeout();
    test_reset_mid();
    test_alu_pass();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
